mux_parity_pipe: RTL and testbench
==================================

MUX_PARITY_PIPE -- requirements
Module: mux_parity_pipe

Interface
REQ-001 Parameter NCH, default 4: number of output channels, legal range 1..16.
REQ-002 Parameter W, default 8: data width per source and channel, legal range 1..32.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset is synchronous and active-high.
REQ-005 Port src, input, 4*W: four shared sources; source k occupies bits [k*W +: W].
REQ-006 Port sel, input, 2*NCH: channel i selects source sel[2i +: 2].
REQ-007 Port en, input, NCH: channel i is enabled when en[i] = 1; a disabled channel outputs 0.
REQ-008 Port in_valid, input, 1, and in_ready, output, 1: input handshake.
REQ-009 Port out_valid, output, 1, and out_ready, input, 1: output handshake.
REQ-010 Port chan_out, output, NCH*W: selected data for each channel.
REQ-011 Port parity, output, W: bitwise XOR of all chan_out words.
REQ-012 Port any_en, output, 1: OR of en captured with the transfer.

Function
REQ-013 An input transfer occurs when in_valid and in_ready are both 1 on a rising edge; an output transfer occurs when out_valid and out_ready are both 1.
REQ-014 Stage S1 shall register, per channel, en[i] ? src[sel[i]] : 0, together with any_en and a valid bit.
REQ-015 Stage S2 shall register the S1 channel words unchanged, the XOR reduction of those words as parity, any_en, and a valid bit.
REQ-016 Latency from input transfer to out_valid shall be exactly 2 cycles when out_ready is held at 1.
REQ-017 Throughput shall be one transfer per cycle when out_ready is held at 1.
REQ-018 S2 shall load when it is empty or its output is transferring that cycle; S1 shall load when it is empty or S2 is loading that cycle.
REQ-019 in_ready shall equal !S1.valid || S2 load-enable, and shall be combinational from out_ready.
REQ-020 While out_valid = 1 and out_ready = 0, chan_out, parity and any_en shall hold stable and no data shall be lost or duplicated.
REQ-021 When both stages are full and out_ready = 0, in_ready shall be 0.
REQ-022 When the output is transferring and a new input is accepted in the same cycle, both stages shall advance together.
REQ-023 With NCH = 1, parity shall equal chan_out; with all en = 0, chan_out, parity and any_en shall be 0.
REQ-024 Data registers may be loaded without reset; only valid bits and counters require reset.

Reset
REQ-025 With rst = 1 at a rising edge, S1.valid and S2.valid shall clear to 0; out_valid shall be 0 from the next cycle.
REQ-026 During reset, chan_out, parity and any_en shall read 0, enforced by output gating with out_valid.
REQ-027 Reset mid-operation shall discard all in-flight data; in_ready shall be 1 in the first cycle after rst falls.

Configuration
REQ-028 Macro MUX_PARITY_PIPE_CHECK_EN shall add port exp_parity, input, W, captured into S1 with the transfer.
REQ-029 With MUX_PARITY_PIPE_CHECK_EN defined, the block shall also add ports mismatch, output, 1 (registered in S2: parity != exp_parity, qualified by out_valid) and err_cnt, output, 16.
REQ-030 err_cnt shall increment on each output transfer with mismatch = 1, saturate at 0xFFFF, and reset to 0.
REQ-031 Without MUX_PARITY_PIPE_CHECK_EN, the ports exp_parity, mismatch and err_cnt and their logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-032 Reset: hold rst = 1 for 3 cycles -> out_valid = 0, chan_out = 0, parity = 0; in_ready = 1 after release.
REQ-033 Basic select: NCH = 4, W = 8, src = {0x44, 0x33, 0x22, 0x11}, sel = {3, 2, 1, 0}, en = 0xF, out_ready = 1 -> 2 cycles later chan_out = {0x44, 0x33, 0x22, 0x11}, parity = 0x44, any_en = 1.
REQ-034 Disable: same stimulus with en = 0x5 -> chan_out = {0, 0x33, 0, 0x11}, parity = 0x22; with en = 0 -> parity = 0, any_en = 0.
REQ-035 Backpressure: stream 6 words with out_ready = 0 for 4 cycles -> in_ready drops after 2 accepted words; all 6 outputs appear in order with no loss or duplication.
REQ-036 Mid-operation reset: assert rst with both stages full -> next cycle out_valid = 0; previously queued words never appear on the output.
REQ-037 Checker (macro defined): drive exp_parity = 0x00 against actual parity 0x44 for 3 transfers -> mismatch = 1 each time, err_cnt = 3; preload err_cnt to 0xFFFF -> it stays at 0xFFFF.

Source files
------------

// File: rtl/mux_parity_pipe.sv
// Four-source per-channel mux with a two-stage valid/ready pipeline and XOR parity.
// Optional parity checker enabled by defining MUX_PARITY_PIPE_CHECK_EN.
module mux_parity_pipe #(
   parameter int unsigned NCH = 4,
   parameter int unsigned W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4*W-1:0]   src,
   input  logic [2*NCH-1:0] sel,
   input  logic [NCH-1:0]   en,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NCH*W-1:0] chan_out,
   output logic [W-1:0]     parity,
   output logic             any_en
`ifdef MUX_PARITY_PIPE_CHECK_EN
   ,
   input  logic [W-1:0]     exp_parity,
   output logic             mismatch,
   output logic [15:0]      err_cnt
`endif
);

   logic             s1_valid_q, s2_valid_q;
   logic [NCH*W-1:0] s1_data_q, s2_data_q;
   logic             s1_any_q, s2_any_q;
   logic [W-1:0]     s2_par_q;
   logic             s1_en, s2_en;
   logic [NCH*W-1:0] s1_data_d;
   logic [W-1:0]     par_d;

   assign s2_en    = !s2_valid_q || out_ready;
   assign s1_en    = !s1_valid_q || s2_en;
   assign in_ready = s1_en;

   always_comb begin
      s1_data_d = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (en[i]) s1_data_d[i*W +: W] = src[int'(sel[2*i +: 2])*int'(W) +: W];
      end
   end

   always_comb begin
      par_d = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         par_d = par_d ^ s1_data_q[i*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         if (s1_en) s1_valid_q <= in_valid;
         if (s2_en) s2_valid_q <= s1_valid_q;
      end
   end

   // Data stages carry no reset; outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (s1_en && in_valid) begin
         s1_data_q <= s1_data_d;
         s1_any_q  <= |en;
      end
      if (s2_en && s1_valid_q) begin
         s2_data_q <= s1_data_q;
         s2_par_q  <= par_d;
         s2_any_q  <= s1_any_q;
      end
   end

   assign out_valid = s2_valid_q;
   assign chan_out  = out_valid ? s2_data_q : '0;
   assign parity    = out_valid ? s2_par_q : '0;
   assign any_en    = out_valid & s2_any_q;

`ifdef MUX_PARITY_PIPE_CHECK_EN
   logic [W-1:0] s1_exp_q;
   logic         s2_mis_q;
   logic [15:0]  err_cnt_q;

   always_ff @(posedge clk) begin
      if (s1_en && in_valid) s1_exp_q <= exp_parity;
      if (s2_en && s1_valid_q) s2_mis_q <= (par_d != s1_exp_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= 16'h0000;
      end else if (out_valid && out_ready && s2_mis_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'h0001;
      end
   end

   assign mismatch = out_valid & s2_mis_q;
   assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_parity_pipe.sv
// Randomized and directed bench for mux_parity_pipe against a transaction-queue model.
// Checker tests are compiled when MUX_PARITY_PIPE_CHECK_EN is defined.
module tb_mux_parity_pipe;
   localparam int unsigned NCH = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned CW  = NCH * W;

   logic             clk;
   logic             rst;
   logic [4*W-1:0]   src;
   logic [2*NCH-1:0] sel;
   logic [NCH-1:0]   en;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [CW-1:0]    chan_out;
   logic [W-1:0]     parity;
   logic             any_en;
   logic [W-1:0]     exp_parity_s;
`ifdef MUX_PARITY_PIPE_CHECK_EN
   logic             mismatch;
   logic [15:0]      err_cnt;
`endif

   mux_parity_pipe #(.NCH(NCH), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .src       (src),
      .sel       (sel),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .chan_out  (chan_out),
      .parity    (parity),
      .any_en    (any_en)
`ifdef MUX_PARITY_PIPE_CHECK_EN
      ,
      .exp_parity(exp_parity_s),
      .mismatch  (mismatch),
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] chan;
      logic [W-1:0]  par;
      logic          any;
      logic          mis;
   } txn_t;

   txn_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_err  = 0;
   logic        last_in_ready, last_in_fire;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic txn_t model(input logic [4*W-1:0] s, input logic [2*NCH-1:0] sl,
                                  input logic [NCH-1:0] e, input logic [W-1:0] x);
      txn_t t;
      t.chan = '0;
      t.par  = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         int unsigned k;
         logic [W-1:0] word;
         k    = (int'(sl) >> (2 * i)) % 4;
         word = e[i] ? W'(s >> (k * W)) : '0;
         t.chan = t.chan | (CW'(word) << (i * W));
         t.par  = t.par ^ word;
      end
      t.any = (e != '0);
      t.mis = (t.par != x);
      return t;
   endfunction

   // Drive one cycle of stimulus from a negedge, check just after, then advance to next negedge.
   task automatic cycle(input logic [4*W-1:0] s, input logic [2*NCH-1:0] sl,
                        input logic [NCH-1:0] e, input logic [W-1:0] x,
                        input logic iv, input logic ordy, input logic r);
      txn_t f;
      src = s; sel = sl; en = e; exp_parity_s = x;
      in_valid = iv; out_ready = ordy; rst = r;
      #1;
      last_in_ready = in_ready;
      last_in_fire  = iv && in_ready;
      if (r) begin
         q.delete();
         exp_err = 0;
      end else begin
         check_eq("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
         if (q.size() == 0) check_eq("out_valid_empty", 64'(out_valid), 64'(0));
         if (out_valid && q.size() > 0) begin
            f = q[0];
            check_eq("chan_out", 64'(chan_out), 64'(f.chan));
            check_eq("parity", 64'(parity), 64'(f.par));
            check_eq("any_en", 64'(any_en), 64'(f.any));
`ifdef MUX_PARITY_PIPE_CHECK_EN
            check_eq("mismatch", 64'(mismatch), 64'(f.mis));
`endif
         end else begin
            check_eq("chan_out_gated", 64'(chan_out), 64'(0));
            check_eq("parity_gated", 64'(parity), 64'(0));
            check_eq("any_en_gated", 64'(any_en), 64'(0));
         end
`ifdef MUX_PARITY_PIPE_CHECK_EN
         check_eq("err_cnt", 64'(err_cnt), 64'(exp_err));
`endif
         if (out_valid && ordy && q.size() > 0) begin
            f = q.pop_front();
            if (f.mis && exp_err < 32'hFFFF) exp_err++;
         end
         if (iv && in_ready) q.push_back(model(s, sl, e, x));
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, 1'b0, ordy, 1'b0);
   endtask

   localparam logic [4*W-1:0]   BASIC_SRC = 32'h44332211;
   localparam logic [2*NCH-1:0] BASIC_SEL = 8'hE4;

   initial begin
      int acc;
      // Reset held three cycles
      for (int i = 0; i < 3; i++) cycle('0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_chan_out", 64'(chan_out), 64'(0));
      check_eq("rst_parity", 64'(parity), 64'(0));
      idle(1, 1'b1);
      check_eq("rst_in_ready", 64'(last_in_ready), 64'(1));

      // Basic select and two-cycle latency
      cycle(BASIC_SRC, BASIC_SEL, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0);
      check_eq("lat_1cyc", 64'(out_valid), 64'(0));
      idle(1, 1'b0);
      check_eq("lat_2cyc", 64'(out_valid), 64'(1));
      check_eq("basic_chan", 64'(chan_out), 64'(32'h44332211));
      check_eq("basic_par", 64'(parity), 64'(8'h44));
      check_eq("basic_any", 64'(any_en), 64'(1));
      idle(1, 1'b1);

      // Partial and full disable
      cycle(BASIC_SRC, BASIC_SEL, 4'h5, 8'h22, 1'b1, 1'b1, 1'b0);
      cycle(BASIC_SRC, BASIC_SEL, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0);
      check_eq("dis5_chan", 64'(chan_out), 64'(32'h00330011));
      check_eq("dis5_par", 64'(parity), 64'(8'h22));
      idle(1, 1'b1);
      check_eq("dis0_par", 64'(parity), 64'(0));
      check_eq("dis0_any", 64'(any_en), 64'(0));
      check_eq("dis0_valid", 64'(out_valid), 64'(1));
      idle(2, 1'b1);

      // Backpressure: six words, out_ready low for four cycles
      acc = 0;
      for (int c = 0; c < 16; c++) begin
         cycle(32'h01010101 * (acc + 1), BASIC_SEL, 4'hF, 8'h00, acc < 6, c >= 4, 1'b0);
         if (last_in_fire) acc++;
         if (c == 2) begin
            check_eq("bp_in_ready_low", 64'(last_in_ready), 64'(0));
            check_eq("bp_accepted", 64'(acc), 64'(2));
         end
      end
      check_eq("bp_all_accepted", 64'(acc), 64'(6));
      check_eq("bp_drained", 64'(q.size()), 64'(0));

      // Mid-operation reset with both stages full
      cycle(BASIC_SRC, BASIC_SEL, 4'hF, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(BASIC_SRC, BASIC_SEL, 4'h3, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
      idle(1, 1'b1);
      check_eq("midrst_in_ready", 64'(last_in_ready), 64'(1));
      idle(4, 1'b1);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         cycle((4*W)'({$urandom(), $urandom()}), (2*NCH)'($urandom()), NCH'($urandom()),
               W'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
      end
      idle(4, 1'b1);
      check_eq("rand_drained", 64'(q.size()), 64'(0));

`ifdef MUX_PARITY_PIPE_CHECK_EN
      // Checker: three mismatching transfers, then saturation
      cycle('0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(BASIC_SRC, BASIC_SEL, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("chk_err_cnt3", 64'(err_cnt), 64'(3));
      for (int i = 0; i < 65540; i++) cycle(BASIC_SRC, BASIC_SEL, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("chk_err_sat", 64'(err_cnt), 64'(16'hFFFF));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
